usb_fs_in_stream_ep: RTL and testbench

- Streaming IN endpoint that sits directly upstream of the full-speed protocol engine's IN endpoint port.
- Accepts an application byte stream (valid/ready) into an internal FIFO.
- Requests the IN arbiter, loads packets of up to MAX_PKT bytes into the engine's IN buffer, and waits for the host ACK.
- Flushes short packets after an idle timeout; sends a zero-length packet (ZLP) after a full-size packet when no data follows.

---
 rtl/usb_fs_in_stream_ep.sv | 170 +++++++++++++++++
 tb/tb_usb_fs_in_stream_ep.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_fs_in_stream_ep.sv
// Streaming IN endpoint: buffers an application byte stream and hands it to
// the full-speed protocol engine as packets of up to MAX_PKT bytes. Short
// packets, and a ZLP after a full-size packet, go out after an idle timeout.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | collecting bytes, idle timer running
// REQ      | requesting the IN arbiter, waiting for grant
// FILL     | copying pkt_len bytes from the FIFO into the PE buffer
// DONE     | one-cycle packet-complete strobe
// WAIT_ACK | packet handed off, waiting for the host ACK
module usb_fs_in_stream_ep #(
  parameter int MAX_PKT       = 64,
  parameter int FIFO_DEPTH    = 128,
  parameter int FLUSH_TIMEOUT = 48000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        stall,
  output logic                        in_ep_req,
  input  logic                        in_ep_grant,
  input  logic                        in_ep_data_free,
  output logic                        in_ep_data_put,
  output logic [7:0]                  in_ep_data,
  output logic                        in_ep_data_done,
  output logic                        in_ep_stall,
  input  logic                        in_ep_acked,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = $clog2(MAX_PKT + 1);
  localparam int TW = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;

  localparam logic [LW-1:0] C_DEPTH   = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] C_MAX_LVL = LW'(MAX_PKT);
  localparam logic [PW-1:0] C_MAX_LEN = PW'(MAX_PKT);
  localparam logic [TW-1:0] C_TMO     = TW'(FLUSH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_FILL,
    ST_DONE,
    ST_WAIT_ACK
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic [TW-1:0]   r_timer;
  logic [PW-1:0]   r_pkt_len;
  logic [PW-1:0]   r_pkt_cnt;
  logic            r_zlp_pending;
  logic            w_push;
  logic            w_pop;
  logic            w_expired;
  logic [PW-1:0]   w_len_sel;

  // s_ready is forced low while reset is held, independent of the clock
  assign s_ready     = reset & (r_level != C_DEPTH);
  assign w_push      = s_valid & s_ready;
  assign w_pop       = in_ep_data_put;
  assign in_ep_data  = (r_level != '0) ? r_mem[r_rd_ptr] : 8'h00;
  assign in_ep_stall = stall;
  assign fifo_level  = r_level;
  assign w_expired   = (r_timer == C_TMO);
  assign w_len_sel   = (r_level >= C_MAX_LVL) ? C_MAX_LEN : r_level[PW-1:0];

  // FIFO storage; contents need no reset since r_level gates the head
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // idle timer: counts quiet IDLE cycles, saturating at the flush point
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timer <= '0;
    end else if (w_push || r_state != ST_IDLE) begin
      r_timer <= '0;
    end else if (!w_expired) begin
      r_timer <= r_timer + TW'(1);
    end
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // packet length/count latch and ZLP bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pkt_len     <= '0;
      r_pkt_cnt     <= '0;
      r_zlp_pending <= 1'b0;
    end else begin
      if (r_state == ST_REQ && in_ep_grant) begin
        r_pkt_len     <= w_len_sel;
        r_pkt_cnt     <= '0;
        r_zlp_pending <= 1'b0;
      end else if (w_pop) begin
        r_pkt_cnt <= r_pkt_cnt + PW'(1);
      end
      if (r_state == ST_WAIT_ACK && in_ep_acked) begin
        r_zlp_pending <= (r_pkt_len == C_MAX_LEN);
      end
    end
  end

  // next-state and PE handshake outputs
  always_comb begin
    w_state_nxt     = r_state;
    in_ep_req       = 1'b0;
    in_ep_data_put  = 1'b0;
    in_ep_data_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_level >= C_MAX_LVL ||
            (w_expired && (r_level != '0 || r_zlp_pending))) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        in_ep_req = 1'b1;
        if (in_ep_grant) w_state_nxt = ST_FILL;
      end
      ST_FILL: begin
        in_ep_req      = 1'b1;
        in_ep_data_put = in_ep_data_free & (r_pkt_cnt < r_pkt_len);
        if (r_pkt_cnt == r_pkt_len) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        in_ep_req       = 1'b1;
        in_ep_data_done = 1'b1;
        w_state_nxt     = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (in_ep_acked) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_usb_fs_in_stream_ep.sv
// Bench for usb_fs_in_stream_ep: randomized stream and PE responder, checked
// against a byte-queue / packet-phase reference model.
module tb_usb_fs_in_stream_ep;

  localparam int MAX   = 64;
  localparam int DEPTH = 128;
  localparam int F     = 300;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic       stall = 1'b0;
  logic       in_ep_req;
  logic       in_ep_grant = 1'b0;
  logic       in_ep_data_free = 1'b0;
  logic       in_ep_data_put;
  logic [7:0] in_ep_data;
  logic       in_ep_data_done;
  logic       in_ep_stall;
  logic       in_ep_acked = 1'b0;
  logic [$clog2(DEPTH):0] fifo_level;

  usb_fs_in_stream_ep #(
    .MAX_PKT(MAX), .FIFO_DEPTH(DEPTH), .FLUSH_TIMEOUT(F)
  ) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .stall(stall), .in_ep_req(in_ep_req),
    .in_ep_grant(in_ep_grant), .in_ep_data_free(in_ep_data_free),
    .in_ep_data_put(in_ep_data_put), .in_ep_data(in_ep_data),
    .in_ep_data_done(in_ep_data_done), .in_ep_stall(in_ep_stall),
    .in_ep_acked(in_ep_acked), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model: byte queue plus the packet phase seen from the PE side
  typedef enum {P_IDLE, P_REQ, P_FILL, P_WAIT} ph_t;
  ph_t  ph = P_IDLE;
  byte unsigned q[$];
  int   len_log[$];
  int   m_cnt = 0, exp_len = 0, last_len = 0, puts = 0, settle = 0, age = 0;
  int   pkts = 0, zlps = 0, pushed = 0, popped = 0, max_lvl = 0;
  bit   m_zlp = 0, pred_req = 0, pred_valid = 0, mon_en = 0;

  int   free_mode = 1, gnt_delay = 1, ack_delay = 3;
  bit   stray_en = 0;

  task automatic model_reset();
    q.delete();
    ph = P_IDLE; m_cnt = 0; exp_len = 0; puts = 0; settle = 0; age = 0;
    m_zlp = 0; pred_valid = 0; pushed = 0; popped = 0;
  endtask

  // monitor: compares DUT against the model once per cycle, mid-cycle
  initial begin : mon
    bit push;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        push = s_valid && s_ready;
        if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
        chk_eq("stall_pass", in_ep_stall, stall);
        chk_eq("fifo_level", fifo_level, m_cnt);
        chk_eq("s_ready", s_ready, m_cnt != DEPTH);
        if (ph == P_IDLE) begin
          if (pred_valid) chk_eq("req_start", in_ep_req, pred_req);
          if (in_ep_req) ph = P_REQ;
        end
        pred_valid = 0;
        case (ph)
          P_IDLE: begin
            chk_eq("idle_put", in_ep_data_put, 0);
            chk_eq("idle_done", in_ep_data_done, 0);
            pred_req = (m_cnt >= MAX) || (age >= F - 1 && (m_cnt > 0 || m_zlp));
            pred_valid = 1;
          end
          P_REQ: begin
            chk_eq("req_put", in_ep_data_put, 0);
            chk_eq("req_done", in_ep_data_done, 0);
            if (in_ep_grant) begin
              exp_len = (m_cnt < MAX) ? m_cnt : MAX;
              if (exp_len == 0) chk_eq("zlp_allowed", m_zlp, 1);
              m_zlp = 0; puts = 0; settle = 0;
              ph = P_FILL;
            end
          end
          P_FILL: begin
            chk_eq("fill_req", in_ep_req, 1);
            if (in_ep_data_done) begin
              chk_eq("done_len", puts, exp_len);
              chk_eq("done_latency", settle, 1);
              chk_eq("done_put", in_ep_data_put, 0);
              len_log.push_back(exp_len);
              last_len = exp_len;
              pkts++;
              if (exp_len == 0) zlps++;
              ph = P_WAIT;
            end else begin
              if (puts == exp_len) settle++;
              chk_eq("put_rule", in_ep_data_put, in_ep_data_free && puts < exp_len);
              if (in_ep_data_put) begin
                if (q.size() == 0) chk_eq("data_underflow", 1, 0);
                else begin
                  chk_eq("data_order", in_ep_data, q[0]);
                  void'(q.pop_front());
                end
                puts++; m_cnt--; popped++;
              end
            end
          end
          P_WAIT: begin
            chk_eq("wait_req", in_ep_req, 0);
            chk_eq("wait_put", in_ep_data_put, 0);
            chk_eq("wait_done", in_ep_data_done, 0);
            if (in_ep_acked) begin
              m_zlp = (exp_len == MAX);
              age = 0;
              ph = P_IDLE;
            end
          end
          default: ;
        endcase
        if (ph == P_IDLE && !(in_ep_acked && age == 0)) begin
          if (push) age = 0;
          else if (age < F) age++;
        end
        if (push) begin
          q.push_back(s_data);
          m_cnt++; pushed++;
        end
      end
    end
  end

  // PE responder: grant after a delay, ack after a delay unless stalled,
  // optional stray grant/ack pulses in the wrong phases
  initial begin : resp
    int gw, aw;
    gw = 0; aw = 0;
    forever begin
      @(posedge clk); #1;
      case (free_mode)
        0:       in_ep_data_free = 1'($urandom_range(0, 1));
        1:       in_ep_data_free = 1'b1;
        default: in_ep_data_free = ~in_ep_data_free;
      endcase
      if (!mon_en) begin
        in_ep_grant = 1'b0; in_ep_acked = 1'b0; gw = 0; aw = 0;
      end else begin
        if (ph == P_REQ) begin
          if (gw >= gnt_delay) in_ep_grant = 1'b1;
          else begin in_ep_grant = 1'b0; gw++; end
        end else begin
          gw = 0;
          in_ep_grant = stray_en && ($urandom_range(0, 15) == 0);
        end
        if (ph == P_WAIT) begin
          if (!stall && aw >= ack_delay) in_ep_acked = 1'b1;
          else begin in_ep_acked = 1'b0; if (!stall) aw++; end
        end else begin
          aw = 0;
          in_ep_acked = stray_en && ($urandom_range(0, 15) == 0);
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    int n;
    bit acc;
    n = 0; acc = 0;
    s_valid = 1'b1; s_data = b;
    while (!acc) begin
      @(negedge clk); acc = s_ready;
      @(posedge clk); #1;
      n++;
      if (!acc && n > 4000) begin chk_eq("push_timeout", 0, 1); break; end
    end
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drained(input int max_cyc);
    int n;
    n = 0;
    while (!(ph == P_IDLE && m_cnt == 0 && !m_zlp)) begin
      if (n >= max_cyc) begin chk_eq("drain_timeout", 0, 1); break; end
      @(posedge clk); n++;
    end
    #1;
  endtask

  initial begin : main
    int n, p0, z0, blen;
    repeat (3) @(posedge clk); #1;
    chk_eq("rst_s_ready", s_ready, 0);
    chk_eq("rst_req", in_ep_req, 0);
    chk_eq("rst_put", in_ep_data_put, 0);
    chk_eq("rst_done", in_ep_data_done, 0);
    chk_eq("rst_data", in_ep_data, 0);
    chk_eq("rst_level", fifo_level, 0);
    reset = 1'b1; model_reset(); mon_en = 1;
    #1 chk_eq("ready_after_rst", s_ready, 1);

    // reset asserted mid-FILL after 10 puts
    for (int i = 0; i < 64; i++) push_byte(8'(i));
    n = 0;
    while (!(ph == P_FILL && puts >= 10) && n < 500) begin @(posedge clk); n++; end
    chk_eq("reach_fill10", puts, 10);
    #2; mon_en = 0; reset = 1'b0;
    #1;
    chk_eq("arst_req", in_ep_req, 0);
    chk_eq("arst_put", in_ep_data_put, 0);
    chk_eq("arst_done", in_ep_data_done, 0);
    chk_eq("arst_data", in_ep_data, 0);
    chk_eq("arst_level", fifo_level, 0);
    chk_eq("arst_s_ready", s_ready, 0);
    idle(3);
    reset = 1'b1; model_reset(); mon_en = 1;
    #1 chk_eq("ready_after_arst", s_ready, 1);

    // full packet 0x00..0x3F followed by a ZLP
    len_log.delete(); z0 = zlps;
    for (int i = 0; i < 64; i++) push_byte(8'(i));
    wait_drained(2000);
    chk_eq("a_pkts", len_log.size(), 2);
    if (len_log.size() == 2) begin
      chk_eq("a_len0", len_log[0], 64);
      chk_eq("a_len1", len_log[1], 0);
    end
    chk_eq("a_zlps", zlps - z0, 1);

    // short packet flushed by timeout, no ZLP afterwards
    p0 = pkts; z0 = zlps;
    for (int i = 0; i < 5; i++) push_byte(8'(8'hA0 + i));
    wait_drained(1000);
    chk_eq("b_len5", last_len, 5);
    idle(F + 50);
    chk_eq("b_pkts", pkts - p0, 1);
    chk_eq("b_no_zlp", zlps - z0, 0);

    // 200 bytes against a slow ACK: FIFO fills, packets 64,64,64,8
    ack_delay = 100; len_log.delete(); max_lvl = 0;
    for (int i = 0; i < 200; i++) push_byte(8'(i * 7 + 3));
    wait_drained(5000);
    chk_eq("c_full_seen", max_lvl, DEPTH);
    chk_eq("c_pkts", len_log.size(), 4);
    if (len_log.size() == 4) begin
      chk_eq("c_len0", len_log[0], 64);
      chk_eq("c_len1", len_log[1], 64);
      chk_eq("c_len2", len_log[2], 64);
      chk_eq("c_len3", len_log[3], 8);
    end

    // data_free toggling every cycle during FILL
    ack_delay = 3; free_mode = 2; len_log.delete();
    for (int i = 0; i < 64; i++) push_byte(8'(255 - i));
    wait_drained(2000);
    chk_eq("d_pkts", len_log.size(), 2);
    if (len_log.size() >= 1) chk_eq("d_len", len_log[0], 64);

    // randomized bursts, stray grant/ack pulses, stall windows
    free_mode = 0; stray_en = 1;
    for (int b = 0; b < 20; b++) begin
      gnt_delay = $urandom_range(0, 4);
      ack_delay = $urandom_range(0, 20);
      blen = $urandom_range(1, 90);
      for (int i = 0; i < blen; i++) begin
        push_byte(8'($urandom));
        if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 5));
      end
      if ($urandom_range(0, 3) == 0) begin
        stall = 1'b1; idle($urandom_range(5, 40)); stall = 1'b0;
      end
      idle($urandom_range(0, 80));
    end
    stray_en = 0;
    wait_drained(8000);
    chk_eq("e_conserved", popped, pushed);
    chk_eq("e_leftover", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
